// File: rtl/demux_1x4_sched.sv
// ---------------------------------------------------------------------------
// demux_1x4_sched
//
// Sequencing controller for a 1-to-4 demultiplexer. Words arrive on one
// valid/ready stream and are delivered to exactly one of four channels,
// chosen by an explicit destination (addressed mode) or by round-robin over
// the enabled channels. A held word that a round-robin channel does not take
// within TIMEOUT cycles is moved to the next enabled channel.
//
// Parameters:
//   DATA_W   width of the data word
//   TIMEOUT  SEND cycles before a round-robin reroute (1..255)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data, in_dest    input word and its destination (addressed mode)
//   mode                0 = addressed, 1 = round-robin (sampled on accept)
//   ch_en               per-channel enable
//   sel                 demux select of the held word
//   out_valid           one-hot per-channel valid
//   out_data            registered word, shared by all channels
//   out_ready           per-channel ready
//   busy                a word is held
//   drop_cnt            saturating count of dropped words
//   dlv_cnt             four 8-bit wrapping delivery counters {ch3..ch0}
//                       (present only with DEMUX_SCHED_STATS_EN)
//
// Optional feature macro: DEMUX_SCHED_STATS_EN
// ---------------------------------------------------------------------------
module demux_1x4_sched #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              mode,
    input  logic [3:0]        ch_en,
    output logic [1:0]        sel,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        out_ready,
    output logic              busy,
    output logic [7:0]        drop_cnt
`ifdef DEMUX_SCHED_STATS_EN
    ,
    output logic [31:0]       dlv_cnt
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        drop_q, drop_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic [7:0]        wait_q, wait_d;
    logic              mode_q, mode_d;
    logic [31:0]       dlv_q, dlv_d;

    // Returns {found, index} of the first enabled channel at base+1, base+2,
    // base+3 and, when incl_base is set, base itself (mod 4).
    function automatic logic [2:0] first_en(input logic [3:0] en,
                                            input logic [1:0] base,
                                            input logic       incl_base);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        // Walk from the farthest offset down so the nearest match wins.
        for (int off = 4; off >= 1; off--) begin
            idx = base + 2'(off);
            if (en[idx] && (off != 4 || incl_base)) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    logic [7:0] drop_inc;
    logic [7:0] wait_inc;
    logic [2:0] pick;
    logic [1:0] tgt;
    logic       tgt_ok;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        drop_d    = drop_q;
        rr_last_d = rr_last_q;
        wait_d    = wait_q;
        mode_d    = mode_q;
        dlv_d     = dlv_q;
        pick      = 3'b000;
        tgt       = in_dest;
        tgt_ok    = 1'b0;
        drop_inc  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        wait_inc  = wait_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mode) begin
                        pick   = first_en(ch_en, rr_last_q, 1'b1);
                        tgt    = pick[1:0];
                        tgt_ok = pick[2];
                    end else begin
                        tgt    = in_dest;
                        tgt_ok = ch_en[in_dest];
                    end
                    if (tgt_ok) begin
                        data_d  = in_data;
                        sel_d   = tgt;
                        mode_d  = mode;
                        wait_d  = 8'd0;
                        state_d = SEND;
                    end else begin
                        drop_d  = drop_inc;
                    end
                end
            end
            SEND: begin
                if (out_ready[sel_q]) begin
                    // Delivery beats a same-cycle disable or timeout.
                    state_d = IDLE;
                    wait_d  = 8'd0;
                    if (mode_q) rr_last_d = sel_q;
                    dlv_d[{sel_q, 3'b000} +: 8] = dlv_q[{sel_q, 3'b000} +: 8] + 8'd1;
                end else if (!ch_en[sel_q]) begin
                    state_d = IDLE;
                    wait_d  = 8'd0;
                    drop_d  = drop_inc;
                end else if (mode_q) begin
                    if (wait_inc == TIMEOUT_W) begin
                        // Reroute to the next enabled channel, never the current one.
                        pick   = first_en(ch_en, sel_q, 1'b0);
                        if (pick[2]) sel_d = pick[1:0];
                        wait_d = 8'd0;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    // Addressed words never reroute; the counter just saturates.
                    wait_d = (wait_q == TIMEOUT_W) ? wait_q : wait_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            data_q    <= '0;
            drop_q    <= 8'd0;
            rr_last_q <= 2'd3;
            wait_q    <= 8'd0;
            mode_q    <= 1'b0;
            dlv_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
            rr_last_q <= rr_last_d;
            wait_q    <= wait_d;
            mode_q    <= mode_d;
            dlv_q     <= dlv_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == SEND);
    assign out_valid = busy ? (4'b0001 << sel_q) : 4'b0000;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_q;

`ifdef DEMUX_SCHED_STATS_EN
    assign dlv_cnt = dlv_q;
`else
    // Delivery counters are only observable with the statistics port.
    logic unused_dlv;
    assign unused_dlv = ^dlv_q;
`endif

endmodule
